ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the RAM port arbiter: FSM state encoding, the
// default geometry (address width, word width) and the default read-grant
// starvation limit. Imported by ram_port_arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF     = 22;
    localparam int DATA_W_DEF     = 128;
    localparam int STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_LD = 2'd1,
        GRANT_RD = 2'd2,
        WAIT_RD  = 2'd3
    } arb_state_t;

    // True in the states where a transaction is being offered to memory.
    function automatic logic is_grant_state(input arb_state_t st);
        return (st == GRANT_LD) || (st == GRANT_RD);
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Arbitrates one memory port between a loader (writes) and a display
// reader (reads). Reads normally win, but after STARVE_MAX consecutive read
// grants with a loader write waiting, the loader is served next.
//
// Ports
//   clk50, reset         clock (rising edge) and synchronous active-high reset
//   ld_we/ld_addr/ld_data  loader write request, held until ld_op_begun
//   ld_op_begun          loader acknowledge pulse (combinational)
//   rd_req/rd_addr       display read request, held until rd_ack
//   rd_ack               read acknowledge pulse (combinational)
//   rd_data/rd_valid     returned read word and its one-cycle valid pulse
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory transaction
//   mem_ack              memory accepted the transaction
//   mem_rdata/mem_rdata_valid  memory read return
//
// Build option
//   RAM_ARB_STATS_EN     adds 32-bit wrapping acknowledge counters
//                        ld_grant_cnt and rd_grant_cnt.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_op_begun,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [31:0]       ld_grant_cnt,
    output logic [31:0]       rd_grant_cnt
`endif
);

    localparam int              SC_W         = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIMIT = SC_W'(STARVE_MAX);

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    logic [SC_W-1:0]   starve_cnt_r;

    logic              grant_ld_s;
    logic              grant_rd_s;
    logic              ld_op_begun_s;
    logic              rd_ack_s;
    logic              rd_done_s;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;

    // State register.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: reads win unless the loader has been starved too long.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rd_req && (!ld_we || (starve_cnt_r < STARVE_LIMIT))) begin
                    state_next_s = GRANT_RD;
                end else if (ld_we) begin
                    state_next_s = GRANT_LD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT_LD: begin
                if (mem_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GRANT_LD;
                end
            end
            GRANT_RD: begin
                if (mem_ack) begin
                    state_next_s = WAIT_RD;
                end else begin
                    state_next_s = GRANT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_rdata_valid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_RD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode. Reset suppresses every pulse so an aborted transaction
    // never produces an acknowledge.
    always_comb begin
        grant_ld_s    = 1'b0;
        grant_rd_s    = 1'b0;
        ld_op_begun_s = 1'b0;
        rd_ack_s      = 1'b0;
        rd_done_s     = 1'b0;
        if (reset) begin
            grant_ld_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    grant_ld_s = (state_next_s == GRANT_LD);
                    grant_rd_s = (state_next_s == GRANT_RD);
                end
                GRANT_LD: begin
                    ld_op_begun_s = mem_ack;
                end
                GRANT_RD: begin
                    rd_ack_s = mem_ack;
                end
                WAIT_RD: begin
                    rd_done_s = mem_rdata_valid;
                end
                default: begin
                    grant_ld_s = 1'b0;
                end
            endcase
        end
    end

    // Memory-side transaction registers, loaded on the IDLE->GRANT edge.
    always_ff @(posedge clk50) begin
        if (reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_req_r <= is_grant_state(state_next_s);
            if (grant_ld_s) begin
                mem_we_r    <= 1'b1;
                mem_addr_r  <= ld_addr;
                mem_wdata_r <= ld_data;
            end else if (grant_rd_s) begin
                mem_we_r   <= 1'b0;
                mem_addr_r <= rd_addr;
            end
        end
    end

    // Starvation counter: counts read grants taken over a waiting loader.
    always_ff @(posedge clk50) begin
        if (reset) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (grant_ld_s) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (grant_rd_s && ld_we && (starve_cnt_r != STARVE_LIMIT)) begin
            starve_cnt_r <= starve_cnt_r + SC_W'(1);
        end
    end

    // Read return: capture the word and pulse valid one cycle later.
    always_ff @(posedge clk50) begin
        if (reset) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_done_s;
            if (rd_done_s) begin
                rd_data_r <= mem_rdata;
            end
        end
    end

    assign ld_op_begun = ld_op_begun_s;
    assign rd_ack      = rd_ack_s;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign rd_data     = rd_data_r;
    assign rd_valid    = rd_valid_r;

`ifdef RAM_ARB_STATS_EN
    logic [31:0] ld_grant_cnt_r;
    logic [31:0] rd_grant_cnt_r;

    // Acknowledge counters, free-running and wrapping.
    always_ff @(posedge clk50) begin
        if (reset) begin
            ld_grant_cnt_r <= 32'd0;
            rd_grant_cnt_r <= 32'd0;
        end else begin
            if (ld_op_begun_s) begin
                ld_grant_cnt_r <= ld_grant_cnt_r + 32'd1;
            end
            if (rd_ack_s) begin
                rd_grant_cnt_r <= rd_grant_cnt_r + 32'd1;
            end
        end
    end

    assign ld_grant_cnt = ld_grant_cnt_r;
    assign rd_grant_cnt = rd_grant_cnt_r;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
